apb_completer_mem: RTL and testbench

//  APB4 completer (slave) memory model that sits downstream of the APB requester interface.
//  - Consumes paddr/pprot/psel/penable/pwrite/pwdata/pstrb; produces pready/prdata/pslverr.
//  - Provides a byte-writable word memory with programmable wait states and error responses.
//  - Serves as the DUT-side endpoint for agent self-tests and as a reusable bus target.

---
 rtl/apb_pkg.sv | 26 ++
 rtl/apb_completer_mem_array.sv | 29 ++
 rtl/apb_completer_mem.sv | 167 ++++++++++++++++
 tb/tb_apb_completer_mem.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB types: protection attributes, transfer direction, completer FSM state
// and the byte-address LSB helper.
package apb_pkg;

   typedef struct packed {
      logic instr;
      logic nonsecure;
      logic privileged;
   } apb_pprot_t;

   typedef enum logic {
      APB_READ  = 1'b0,
      APB_WRITE = 1'b1
   } apb_write_t;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } apb_completer_state_e;

   // Number of byte-offset bits below the word index for a given data width.
   function automatic int unsigned apb_addr_lsb(input int unsigned data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/apb_completer_mem_array.sv
// Word storage for apb_completer_mem: per-byte write enables, asynchronous read port.
// Contents are deliberately not reset.
module apb_completer_mem_array #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MEM_DEPTH  = 256
) (
   input  logic                         clk,
   input  logic [DATA_WIDTH/8-1:0]      be,
   input  logic [$clog2(MEM_DEPTH)-1:0] waddr,
   input  logic [DATA_WIDTH-1:0]        wdata,
   input  logic [$clog2(MEM_DEPTH)-1:0] raddr,
   output logic [DATA_WIDTH-1:0]        rdata
);

   localparam int unsigned BYTES = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
         if (be[i]) begin
            mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/apb_completer_mem.sv
// APB4 completer memory with programmable wait states and error responses.
// Optional APB_COMPLETER_PPROT_CHECK_EN: non-secure accesses to the upper half of memory error.
module apb_completer_mem
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned MEM_DEPTH   = 256,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                    pclk,
   input  logic                    preset,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  apb_pprot_t              pprot,
   input  logic                    psel,
   input  logic                    penable,
   input  apb_write_t              pwrite,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   output logic                    pready,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pslverr
);

   localparam int unsigned BYTES = DATA_WIDTH / 8;
   localparam int unsigned LSB   = apb_addr_lsb(DATA_WIDTH);
   localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
   localparam int unsigned CNT_W = 4;
   localparam logic [ADDR_WIDTH:0]   MEM_BYTES  = (ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
   localparam logic [CNT_W-1:0]      WS         = CNT_W'(WAIT_STATES);

   apb_completer_state_e state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [IDX_W-1:0]      idx_q, idx_nxt;
   logic                  err_q, err_nxt;
   apb_write_t            write_q, write_nxt;
   logic                  pready_nxt, pslverr_nxt;
   logic [DATA_WIDTH-1:0] prdata_nxt;

   logic [IDX_W-1:0]      live_idx, ld_idx;
   logic                  live_err, ld_err;
   apb_write_t            ld_write;
   logic [DATA_WIDTH-1:0] rdata, ld_rdata;
   logic [BYTES-1:0]      be;

   // Address decode of the bus as presented this cycle.
   always_comb begin
      live_idx = paddr[LSB +: IDX_W];
      live_err = ({1'b0, paddr} >= MEM_BYTES) || ((paddr & ALIGN_MASK) != '0);
`ifdef APB_COMPLETER_PPROT_CHECK_EN
      if (pprot.nonsecure && live_idx[IDX_W-1]) begin
         live_err = 1'b1;
      end
`endif
   end

`ifndef APB_COMPLETER_PPROT_CHECK_EN
   logic unused_pprot;
   assign unused_pprot = ^pprot;
`endif

   // Response source: live decode on the setup edge, captured transfer afterwards.
   always_comb begin
      ld_idx   = idx_q;
      ld_err   = err_q;
      ld_write = write_q;
      if (state == IDLE) begin
         ld_idx   = live_idx;
         ld_err   = live_err;
         ld_write = pwrite;
      end
   end

   assign ld_rdata = (ld_write == APB_READ && !ld_err) ? rdata : '0;

   apb_completer_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH)
   ) u_array (
      .clk   (pclk),
      .be    (be),
      .waddr (idx_q),
      .wdata (pwdata),
      .raddr (ld_idx),
      .rdata (rdata)
   );

   always_ff @(posedge pclk) begin
      if (preset) begin
         state   <= IDLE;
         cnt     <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
         write_q <= APB_READ;
         pready  <= 1'b0;
         prdata  <= '0;
         pslverr <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         idx_q   <= idx_nxt;
         err_q   <= err_nxt;
         write_q <= write_nxt;
         pready  <= pready_nxt;
         prdata  <= prdata_nxt;
         pslverr <= pslverr_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      idx_nxt     = idx_q;
      err_nxt     = err_q;
      write_nxt   = write_q;
      pready_nxt  = pready;
      prdata_nxt  = prdata;
      pslverr_nxt = pslverr;
      be          = '0;
      case (state)
         IDLE: begin
            if (psel && !penable) begin
               state_nxt  = ACCESS;
               idx_nxt    = live_idx;
               err_nxt    = live_err;
               write_nxt  = pwrite;
               cnt_nxt    = WS;
               pready_nxt = (WS == '0);
               if (WS == '0) begin
                  prdata_nxt  = ld_rdata;
                  pslverr_nxt = ld_err;
               end
            end
         end
         ACCESS: begin
            if (!psel) begin
               state_nxt   = IDLE;
               cnt_nxt     = '0;
               pready_nxt  = 1'b0;
               prdata_nxt  = '0;
               pslverr_nxt = 1'b0;
            end else if (pready) begin
               if (penable) begin
                  // A reset on the completion edge must suppress the commit.
                  if (write_q == APB_WRITE && !err_q && !preset) begin
                     be = pstrb;
                  end
                  state_nxt   = IDLE;
                  pready_nxt  = 1'b0;
                  prdata_nxt  = '0;
                  pslverr_nxt = 1'b0;
               end
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  pready_nxt  = 1'b1;
                  prdata_nxt  = ld_rdata;
                  pslverr_nxt = ld_err;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_apb_completer_mem.sv
// Bench for apb_completer_mem: two instances (0 and 3 wait states) on a shared, gated bus,
// checked against a word-array model of the memory and the decode rules.
module tb_apb_completer_mem;
   import apb_pkg::*;

   localparam int WS0 = 0;
   localparam int WS1 = 3;

   logic        clk;
   logic        preset;
   logic [31:0] paddr;
   logic [2:0]  pprot_b;
   logic        psel;
   logic        penable;
   logic        pwrite_b;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   int          dut_sel;

   logic        pready0, pready1, pslverr0, pslverr1;
   logic [31:0] prdata0, prdata1;
   logic        obs_ready, obs_err;
   logic [31:0] obs_rdata;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem_model [2][256];

   apb_completer_mem #(.WAIT_STATES(WS0)) dut0 (
      .pclk    (clk),
      .preset  (preset),
      .paddr   (paddr),
      .pprot   (apb_pprot_t'(pprot_b)),
      .psel    (psel && dut_sel == 0),
      .penable (penable),
      .pwrite  (apb_write_t'(pwrite_b)),
      .pwdata  (pwdata),
      .pstrb   (pstrb),
      .pready  (pready0),
      .prdata  (prdata0),
      .pslverr (pslverr0)
   );

   apb_completer_mem #(.WAIT_STATES(WS1)) dut1 (
      .pclk    (clk),
      .preset  (preset),
      .paddr   (paddr),
      .pprot   (apb_pprot_t'(pprot_b)),
      .psel    (psel && dut_sel == 1),
      .penable (penable),
      .pwrite  (apb_write_t'(pwrite_b)),
      .pwdata  (pwdata),
      .pstrb   (pstrb),
      .pready  (pready1),
      .prdata  (prdata1),
      .pslverr (pslverr1)
   );

   assign obs_ready = (dut_sel == 1) ? pready1  : pready0;
   assign obs_rdata = (dut_sel == 1) ? prdata1  : prdata0;
   assign obs_err   = (dut_sel == 1) ? pslverr1 : pslverr0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Decode rules: 1 KiB of word-aligned space, optional secure upper half.
   function automatic logic model_err(input logic [31:0] a, input logic [2:0] pr);
      logic e;
      logic prot_check;
`ifdef APB_COMPLETER_PPROT_CHECK_EN
      prot_check = 1'b1;
`else
      prot_check = 1'b0;
`endif
      e = (a >= 32'd1024) || (a % 4 != 0);
      if (prot_check && pr[1] && (a / 4) >= 128) e = 1'b1;
      return e;
   endfunction

   // One full APB transfer; returns response and number of pready-low ACCESS cycles.
   task automatic xfer(input int d, input logic [31:0] a, input logic wr, input logic [31:0] wd,
                       input logic [3:0] sb, input logic [2:0] pr,
                       output logic [31:0] rd, output logic er, output int waits);
      int   cyc;
      logic done;
      dut_sel = d; paddr = a; pwrite_b = wr; pwdata = wd; pstrb = sb; pprot_b = pr;
      psel = 1'b1; penable = 1'b0;
      waits = 0; done = 1'b0; cyc = 0; rd = '0; er = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      while (!done && cyc < 40) begin
         if (obs_ready === 1'b1) begin
            rd = obs_rdata;
            er = obs_err;
            done = 1'b1;
         end else begin
            chk("wait_rdata", obs_rdata, 32'h0);
            chk("wait_err", 32'(obs_err), 32'h0);
            waits++;
            @(posedge clk); #1;
         end
         cyc++;
      end
      chk("completion_seen", 32'(done), 32'h1);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      chk("post_ready", 32'(obs_ready), 32'h0);
      chk("post_rdata", obs_rdata, 32'h0);
      chk("post_err", 32'(obs_err), 32'h0);
   endtask

   task automatic op(input int d, input logic [31:0] a, input logic wr, input logic [31:0] wd,
                     input logic [3:0] sb, input logic [2:0] pr, input string tag);
      logic [31:0] rd, exp_rd;
      logic        er, exp_er;
      int          waits;
      exp_er = model_err(a, pr);
      exp_rd = (wr || exp_er) ? 32'h0 : mem_model[d][a[9:2]];
      xfer(d, a, wr, wd, sb, pr, rd, er, waits);
      chk({tag, "_waits"}, 32'(waits), (d == 0) ? 32'(WS0) : 32'(WS1));
      chk({tag, "_err"}, 32'(er), 32'(exp_er));
      chk({tag, "_rdata"}, rd, exp_rd);
      if (wr && !exp_er) begin
         for (int i = 0; i < 4; i++) begin
            if (sb[i]) mem_model[d][a[9:2]][i*8 +: 8] = wd[i*8 +: 8];
         end
      end
   endtask

   initial begin
      dut_sel = 0; preset = 1'b1; paddr = '0; pprot_b = '0; psel = 1'b0; penable = 1'b0;
      pwrite_b = 1'b0; pwdata = '0; pstrb = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready0", 32'(pready0), 32'h0);
      chk("rst_rdata0", prdata0, 32'h0);
      chk("rst_err0", 32'(pslverr0), 32'h0);
      chk("rst_ready1", 32'(pready1), 32'h0);
      chk("rst_rdata1", prdata1, 32'h0);
      chk("rst_err1", 32'(pslverr1), 32'h0);
      preset = 1'b0;

      for (int i = 0; i < 256; i++) begin
         for (int d = 0; d < 2; d++) op(d, 32'(i) << 2, 1'b1, $urandom, 4'hF, 3'b000, "fill");
      end

      // Full write then read, both wait-state settings.
      for (int d = 0; d < 2; d++) begin
         op(d, 32'h10, 1'b1, 32'h12345678, 4'hF, 3'b000, "wr_full");
         op(d, 32'h10, 1'b0, 32'h0, 4'h0, 3'b000, "rd_full");
         chk("rd_full_value", mem_model[d][4], 32'h12345678);
      end

      // Partial strobes and an all-zero strobe.
      op(0, 32'h10, 1'b1, 32'hAABBCCDD, 4'h5, 3'b000, "wr_strb5");
      op(0, 32'h10, 1'b0, 32'h0, 4'h0, 3'b000, "rd_strb5");
      chk("strb5_value", mem_model[0][4], 32'h12BB56DD);
      op(0, 32'h10, 1'b1, 32'hFFFFFFFF, 4'h0, 3'b000, "wr_strb0");
      op(0, 32'h10, 1'b0, 32'h0, 4'h0, 3'b000, "rd_strb0");

      // Out-of-range and misaligned.
      op(0, 32'h400, 1'b1, 32'hCAFEF00D, 4'hF, 3'b000, "wr_oor");
      op(0, 32'h3FE, 1'b0, 32'h0, 4'h0, 3'b000, "rd_misal");
      op(1, 32'hFFFFFFFC, 1'b0, 32'h0, 4'h0, 3'b000, "rd_top");
      op(0, 32'h0, 1'b0, 32'h0, 4'h0, 3'b000, "rd_alias0");
      op(0, 32'h10, 1'b0, 32'h0, 4'h0, 3'b000, "rd_after_err");

      // Abort: psel drops in the second ACCESS cycle of a 3-wait-state write.
      dut_sel = 1; paddr = 32'h20; pwrite_b = 1'b1; pwdata = 32'hDEADBEEF; pstrb = 4'hF;
      pprot_b = 3'b000; psel = 1'b1; penable = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      chk("abort_c1_ready", 32'(obs_ready), 32'h0);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      chk("abort_ready", 32'(obs_ready), 32'h0);
      chk("abort_rdata", obs_rdata, 32'h0);
      chk("abort_err", 32'(obs_err), 32'h0);
      op(1, 32'h20, 1'b0, 32'h0, 4'h0, 3'b000, "abort_rd");

      // Reset in the middle of ACCESS.
      dut_sel = 1; paddr = 32'h24; pwrite_b = 1'b1; pwdata = 32'h0BADF00D; pstrb = 4'hF;
      psel = 1'b1; penable = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      preset = 1'b1;
      @(posedge clk); #1;
      chk("rstmid_ready", 32'(obs_ready), 32'h0);
      chk("rstmid_rdata", obs_rdata, 32'h0);
      chk("rstmid_err", 32'(obs_err), 32'h0);
      preset = 1'b0; psel = 1'b0; penable = 1'b0;
      op(1, 32'h24, 1'b0, 32'h0, 4'h0, 3'b000, "rstmid_rd");

      // Reset coinciding with the completion edge of a write.
      dut_sel = 0; paddr = 32'h28; pwrite_b = 1'b1; pwdata = 32'h55AA55AA; pstrb = 4'hF;
      psel = 1'b1; penable = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      chk("rstc_ready_before", 32'(obs_ready), 32'h1);
      preset = 1'b1;
      @(posedge clk); #1;
      chk("rstc_ready_after", 32'(obs_ready), 32'h0);
      preset = 1'b0; psel = 1'b0; penable = 1'b0;
      op(0, 32'h28, 1'b0, 32'h0, 4'h0, 3'b000, "rstc_rd");

      // ACCESS-looking bus with no SETUP phase is ignored.
      dut_sel = 0; paddr = 32'h30; pwrite_b = 1'b1; pwdata = 32'h76543210; pstrb = 4'hF;
      psel = 1'b1; penable = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("nosetup_ready", 32'(obs_ready), 32'h0);
      end
      psel = 1'b0; penable = 1'b0;
      op(0, 32'h30, 1'b0, 32'h0, 4'h0, 3'b000, "nosetup_rd");

      // Protection attribute against the upper half of memory.
      op(0, 32'h200, 1'b1, 32'h13579BDF, 4'hF, 3'b010, "prot_ns_wr");
      op(0, 32'h200, 1'b0, 32'h0, 4'h0, 3'b000, "prot_ns_rd");
      op(0, 32'h200, 1'b1, 32'h2468ACE0, 4'hF, 3'b000, "prot_s_wr");
      op(0, 32'h200, 1'b0, 32'h0, 4'h0, 3'b010, "prot_ns_rd2");
      op(0, 32'h200, 1'b0, 32'h0, 4'h0, 3'b000, "prot_s_rd");
      op(1, 32'h1FC, 1'b0, 32'h0, 4'h0, 3'b010, "prot_lower_rd");

      // Randomized traffic.
      for (int n = 0; n < 300; n++) begin
         int          d;
         int          r;
         logic [31:0] a;
         d = int'($urandom_range(0, 1));
         r = int'($urandom_range(0, 9));
         if (r < 8) a = 32'($urandom_range(0, 255)) << 2;
         else if (r == 8) a = 32'h400 + 32'($urandom_range(0, 65535));
         else a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
         op(d, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
            3'($urandom_range(0, 7)), "rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
